ifetch_unit: RTL and testbench



---
 rtl/ifetch_unit_pkg.sv | 12 +
 rtl/ifetch_unit_if.sv | 25 ++
 rtl/ifetch_next_pc.sv | 31 +++
 rtl/ifetch_unit.sv | 106 ++++++++++
 tb/tb_ifetch_unit.sv | 263 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/ifetch_unit_pkg.sv
// Shared definitions for the instruction fetch unit: word width, reset PC and
// the FSM state encodings.
package ifetch_unit_pkg;

  localparam int unsigned WORD_WIDTH       = 32;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  localparam logic [1:0] IFU_BOOT  = 2'd0;
  localparam logic [1:0] IFU_FETCH = 2'd1;
  localparam logic [1:0] IFU_ISSUE = 2'd2;

endpackage

// File: rtl/ifetch_unit_if.sv
// Instruction memory request/response bus seen by the fetch unit.
interface ifetch_unit_if #(
  parameter int unsigned WORD_WIDTH = ifetch_unit_pkg::WORD_WIDTH
);

  logic                  IMemReq;
  logic [WORD_WIDTH-1:0] IMemAddr;
  logic [WORD_WIDTH-1:0] IMemRdata;
  logic                  IMemValid;

  modport master (
    output IMemReq,
    output IMemAddr,
    input  IMemRdata,
    input  IMemValid
  );

  modport slave (
    input  IMemReq,
    input  IMemAddr,
    output IMemRdata,
    output IMemValid
  );

endinterface

// File: rtl/ifetch_next_pc.sv
// Combinational next-PC select: jump beats branch beats sequential PC+4.
module ifetch_next_pc #(
  parameter int unsigned WORD_WIDTH = ifetch_unit_pkg::WORD_WIDTH
) (
  input  logic [WORD_WIDTH-1:0] pc,
  input  logic                  jump,
  input  logic [25:0]           jump_target26,
  input  logic                  branch_taken,
  input  logic [15:0]           branch_offset16,
  output logic [WORD_WIDTH-1:0] pc_plus4,
  output logic [WORD_WIDTH-1:0] next_pc
);

  logic [WORD_WIDTH-1:0] branch_disp;
  logic [WORD_WIDTH-1:0] jump_pc;

  assign pc_plus4    = pc + WORD_WIDTH'(4);
  assign branch_disp = {{(WORD_WIDTH-18){branch_offset16[15]}}, branch_offset16, 2'b00};
  // Jump keeps the region bits of the delay-slot address.
  assign jump_pc     = {pc_plus4[WORD_WIDTH-1:28], jump_target26, 2'b00};

  always_comb begin
    next_pc = pc_plus4;
    if (jump) begin
      next_pc = jump_pc;
    end else if (branch_taken) begin
      next_pc = pc_plus4 + branch_disp;
    end
  end

endmodule

// File: rtl/ifetch_unit.sv
// Instruction fetch stage: holds the PC, fetches over imem, presents Instr to IR.
// Optional watchdog on stuck fetches enabled by defining IFU_TIMEOUT_EN.
module ifetch_unit
  import ifetch_unit_pkg::*;
#(
  parameter int unsigned          WORD_WIDTH     = ifetch_unit_pkg::WORD_WIDTH,
  parameter logic [WORD_WIDTH-1:0] RESET_PC      = RESET_PC_DEFAULT,
  parameter int unsigned          TIMEOUT_CYCLES = 16
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  Stall,
  input  logic                  Jump,
  input  logic [25:0]           JumpTarget26,
  input  logic                  BranchTaken,
  input  logic [15:0]           BranchOffset16,
  ifetch_unit_if.master         imem,
  output logic [WORD_WIDTH-1:0] Instr,
  output logic                  InstrValid,
  output logic [WORD_WIDTH-1:0] PC,
  output logic [WORD_WIDTH-1:0] PCPlus4,
  output logic                  FetchErr
);

  logic [1:0]            state_q, state_d;
  logic [WORD_WIDTH-1:0] pc_q;
  logic [WORD_WIDTH-1:0] instr_q;
  logic                  valid_q;
  logic [WORD_WIDTH-1:0] next_pc;
  logic                  fetch_done;
  logic                  issue_go;

  assign fetch_done = (state_q == IFU_FETCH) && imem.IMemValid;
  assign issue_go   = (state_q == IFU_ISSUE) && !Stall;

  ifetch_next_pc #(
    .WORD_WIDTH (WORD_WIDTH)
  ) u_next_pc (
    .pc              (pc_q),
    .jump            (Jump),
    .jump_target26   (JumpTarget26),
    .branch_taken    (BranchTaken),
    .branch_offset16 (BranchOffset16),
    .pc_plus4        (PCPlus4),
    .next_pc         (next_pc)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      IFU_BOOT:  state_d = IFU_FETCH;
      IFU_FETCH: if (imem.IMemValid) state_d = IFU_ISSUE;
      IFU_ISSUE: if (!Stall) state_d = IFU_FETCH;
      default:   state_d = IFU_BOOT;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IFU_BOOT;
      pc_q    <= RESET_PC;
      instr_q <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (fetch_done) begin
        instr_q <= imem.IMemRdata;
        valid_q <= 1'b1;
      end
      if (issue_go) begin
        pc_q    <= next_pc;
        valid_q <= 1'b0;
      end
    end
  end

  assign imem.IMemReq  = (state_q == IFU_FETCH);
  assign imem.IMemAddr = pc_q;
  assign Instr         = instr_q;
  assign InstrValid    = valid_q;
  assign PC            = pc_q;

`ifdef IFU_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CntW-1:0] tmo_cnt_q;
  logic            timeout;

  // A response in the expiring cycle completes the fetch, so no error.
  assign timeout = (state_q == IFU_FETCH) && !imem.IMemValid &&
                   (tmo_cnt_q == CntW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge CLK) begin
    if (RST || (state_q != IFU_FETCH) || timeout) begin
      tmo_cnt_q <= '0;
    end else if (!imem.IMemValid) begin
      tmo_cnt_q <= tmo_cnt_q + CntW'(1);
    end
  end

  assign FetchErr = timeout;
`else
  assign FetchErr = 1'b0;
`endif

endmodule

// File: tb/tb_ifetch_unit.sv
// Self-checking bench for ifetch_unit: directed scenarios plus randomized
// instruction streams checked against a PC model built from the fetch rules.
module tb_ifetch_unit;

  localparam int unsigned Tmo = 16;

  logic        CLK = 1'b0;
  logic        RST;
  logic        Stall, Jump, BranchTaken;
  logic [25:0] JumpTarget26;
  logic [15:0] BranchOffset16;
  logic [31:0] Instr, PC, PCPlus4;
  logic        InstrValid, FetchErr;

  logic        rst_aux;
  logic [31:0] instr_b, pc_b, pc4_b, instr_c, pc_c, pc4_c;
  logic        ivalid_b, ferr_b, ivalid_c, ferr_c;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  logic [31:0] exp_pc;

  ifetch_unit_if #(.WORD_WIDTH(32)) imem   ();
  ifetch_unit_if #(.WORD_WIDTH(32)) imem_b ();
  ifetch_unit_if #(.WORD_WIDTH(32)) imem_c ();

  always #5 CLK = ~CLK;

  ifetch_unit #(
    .WORD_WIDTH     (32),
    .RESET_PC       (32'h0000_0000),
    .TIMEOUT_CYCLES (Tmo)
  ) dut (
    .CLK            (CLK),
    .RST            (RST),
    .Stall          (Stall),
    .Jump           (Jump),
    .JumpTarget26   (JumpTarget26),
    .BranchTaken    (BranchTaken),
    .BranchOffset16 (BranchOffset16),
    .imem           (imem),
    .Instr          (Instr),
    .InstrValid     (InstrValid),
    .PC             (PC),
    .PCPlus4        (PCPlus4),
    .FetchErr       (FetchErr)
  );

  // Jump-over-branch priority from a non-zero PC region.
  ifetch_unit #(
    .WORD_WIDTH     (32),
    .RESET_PC       (32'h1000_0040),
    .TIMEOUT_CYCLES (Tmo)
  ) dut_b (
    .CLK            (CLK),
    .RST            (rst_aux),
    .Stall          (1'b0),
    .Jump           (1'b1),
    .JumpTarget26   (26'h0000100),
    .BranchTaken    (1'b1),
    .BranchOffset16 (16'h7FFF),
    .imem           (imem_b),
    .Instr          (instr_b),
    .InstrValid     (ivalid_b),
    .PC             (pc_b),
    .PCPlus4        (pc4_b),
    .FetchErr       (ferr_b)
  );

  // Sequential wrap from the top of the address space.
  ifetch_unit #(
    .WORD_WIDTH     (32),
    .RESET_PC       (32'hFFFF_FFFC),
    .TIMEOUT_CYCLES (Tmo)
  ) dut_c (
    .CLK            (CLK),
    .RST            (rst_aux),
    .Stall          (1'b0),
    .Jump           (1'b0),
    .JumpTarget26   (26'h3FFFFFF),
    .BranchTaken    (1'b0),
    .BranchOffset16 (16'h0000),
    .imem           (imem_c),
    .Instr          (instr_c),
    .InstrValid     (ivalid_c),
    .PC             (pc_c),
    .PCPlus4        (pc4_c),
    .FetchErr       (ferr_c)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference next-PC from the architectural rules.
  function automatic logic [31:0] model_next(input logic [31:0] pc, input logic j,
                                             input logic b, input logic [25:0] tgt,
                                             input logic [15:0] off);
    logic [31:0] seq;
    int          disp;
    seq  = pc + 32'd4;
    disp = int'($signed(off)) * 4;
    if (j)      return (seq & 32'hF000_0000) | ({6'd0, tgt} * 32'd4);
    else if (b) return seq + 32'(disp);
    else        return seq;
  endfunction

  function automatic logic exp_timeout(input int fetch_cycle);
`ifdef IFU_TIMEOUT_EN
    return (fetch_cycle % Tmo) == 0;
`else
    return (fetch_cycle < 0);
`endif
  endfunction

  task automatic junk_ctrl();
    Jump           = 1'($urandom);
    BranchTaken    = 1'($urandom);
    JumpTarget26   = 26'($urandom);
    BranchOffset16 = 16'($urandom);
  endtask

  // Entered at a negedge with the DUT in its first FETCH cycle; leaves at the
  // negedge of the following FETCH cycle.
  task automatic do_instr(input int waits, input int stalls, input logic j, input logic b,
                          input logic [25:0] tgt, input logic [15:0] off,
                          input logic [31:0] word);
    Stall = 1'b0;
    for (int w = 0; w < waits; w++) begin
      junk_ctrl();
      imem.IMemValid = 1'b0;
      imem.IMemRdata = $urandom;
      #1;
      check("fetch_req", {31'd0, imem.IMemReq}, 32'd1);
      check("fetch_addr", imem.IMemAddr, exp_pc);
      check("fetch_ivalid", {31'd0, InstrValid}, 32'd0);
      check("fetch_err", {31'd0, FetchErr}, {31'd0, exp_timeout(w + 1)});
      @(negedge CLK);
    end
    imem.IMemValid = 1'b1;
    imem.IMemRdata = word;
    #1;
    check("resp_req", {31'd0, imem.IMemReq}, 32'd1);
    check("resp_addr", imem.IMemAddr, exp_pc);
    check("resp_err", {31'd0, FetchErr}, 32'd0);
    @(negedge CLK);
    imem.IMemValid = 1'b0;
    imem.IMemRdata = $urandom;
    for (int s = 0; s <= stalls; s++) begin
      check("issue_req", {31'd0, imem.IMemReq}, 32'd0);
      check("issue_ivalid", {31'd0, InstrValid}, 32'd1);
      check("issue_instr", Instr, word);
      check("issue_pc", PC, exp_pc);
      check("issue_pc4", PCPlus4, exp_pc + 32'd4);
      if (s < stalls) begin
        Stall = 1'b1;
        junk_ctrl();
        imem.IMemValid = 1'($urandom);
        @(negedge CLK);
        imem.IMemValid = 1'b0;
      end
    end
    Stall          = 1'b0;
    Jump           = j;
    BranchTaken    = b;
    JumpTarget26   = tgt;
    BranchOffset16 = off;
    exp_pc         = model_next(exp_pc, j, b, tgt, off);
    @(negedge CLK);
    junk_ctrl();
    check("next_req", {31'd0, imem.IMemReq}, 32'd1);
    check("next_addr", imem.IMemAddr, exp_pc);
    check("next_ivalid", {31'd0, InstrValid}, 32'd0);
  endtask

  initial begin
    RST = 1'b1;
    rst_aux = 1'b1;
    Stall = 1'b0;
    Jump = 1'b0;
    BranchTaken = 1'b0;
    JumpTarget26 = '0;
    BranchOffset16 = '0;
    imem.IMemValid = 1'b1;
    imem.IMemRdata = 32'hDEAD_BEEF;
    imem_b.IMemValid = 1'b1;
    imem_b.IMemRdata = 32'h1111_1111;
    imem_c.IMemValid = 1'b1;
    imem_c.IMemRdata = 32'h2222_2222;

    repeat (2) @(posedge CLK);
    @(negedge CLK);
    check("rst_pc", PC, 32'h0);
    check("rst_instr", Instr, 32'h0);
    check("rst_ivalid", {31'd0, InstrValid}, 32'd0);
    check("rst_req", {31'd0, imem.IMemReq}, 32'd0);
    check("rst_err", {31'd0, FetchErr}, 32'd0);
    RST = 1'b0;
    @(negedge CLK);
    exp_pc = 32'h0;

    // Zero-wait sequential stream: addresses 0, 4, 8.
    do_instr(0, 0, 1'b0, 1'b0, '0, '0, 32'hA000_0001);
    check("seq_addr1", imem.IMemAddr, 32'h4);
    do_instr(0, 0, 1'b0, 1'b0, '0, '0, 32'hA000_0002);
    check("seq_addr2", imem.IMemAddr, 32'h8);
    do_instr(0, 0, 1'b0, 1'b0, '0, '0, 32'hA000_0003);

    do_instr(3, 4, 1'b0, 1'b0, '0, '0, 32'hB000_0004);
    check("stall_next", imem.IMemAddr, 32'h10);

    do_instr(0, 0, 1'b1, 1'b0, 26'h40, '0, 32'hC000_0005);
    check("jump_0x100", imem.IMemAddr, 32'h100);
    do_instr(1, 0, 1'b0, 1'b1, '0, 16'hFFFE, 32'hC000_0006);
    check("branch_back", imem.IMemAddr, 32'h0FC);
    do_instr(0, 1, 1'b0, 1'b1, '0, 16'h0003, 32'hC000_0007);
    check("branch_fwd", imem.IMemAddr, 32'h10C);

    do_instr(40, 0, 1'b0, 1'b0, '0, '0, 32'hD000_0008);
    do_instr(Tmo - 1, 0, 1'b0, 1'b0, '0, '0, 32'hD000_0009);

    // Reset while a response arrives in FETCH, then a response in BOOT.
    imem.IMemValid = 1'b1;
    imem.IMemRdata = 32'hEEEE_EEEE;
    RST = 1'b1;
    @(negedge CLK);
    check("midrst_instr", Instr, 32'h0);
    check("midrst_ivalid", {31'd0, InstrValid}, 32'd0);
    check("midrst_pc", PC, 32'h0);
    check("midrst_req", {31'd0, imem.IMemReq}, 32'd0);
    RST = 1'b0;
    @(negedge CLK);
    check("boot_instr", Instr, 32'h0);
    check("boot_ivalid", {31'd0, InstrValid}, 32'd0);
    check("boot_addr", imem.IMemAddr, 32'h0);
    exp_pc = 32'h0;

    for (int i = 0; i < 30; i++) begin
      do_instr(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
               ($urandom_range(0, 3) == 0), ($urandom_range(0, 2) == 0),
               26'($urandom), 16'($urandom), $urandom);
    end

    rst_aux = 1'b0;
    @(negedge CLK);
    check("jb_first", imem_b.IMemAddr, 32'h1000_0040);
    check("wrap_first", imem_c.IMemAddr, 32'hFFFF_FFFC);
    @(negedge CLK);
    check("wrap_instr", instr_c, 32'h2222_2222);
    @(negedge CLK);
    check("jb_next", imem_b.IMemAddr, 32'h1000_0400);
    check("wrap_next", imem_c.IMemAddr, 32'h0);
    check("wrap_req", {31'd0, imem_c.IMemReq}, 32'd1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
